// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file.
//   ZERO_WORD  : all-zero data word, wide enough for any supported DATA_W (<= 64)
//   EN_ON/OFF  : enable levels for write/read/scoreboard strobes
//   state_t    : clear-sequencer state encoding (ST_INIT, ST_RUN)
package regfile_mp_pkg;

    localparam int          MAX_DATA_W = 64;
    localparam logic [MAX_DATA_W-1:0] ZERO_WORD = '0;

    localparam logic EN_ON  = 1'b1;
    localparam logic EN_OFF = 1'b0;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle between the core pipeline and the register file.
//   write-back : we0/waddr0/wdata0, we1/waddr1/wdata1 (port 1 has priority)
//   decode     : re, raddr (packed per port), rdata (packed per port)
//   issue      : sb_set/sb_addr claim a destination, sb_busy per read port
//   status     : init_busy while the array is being cleared
// master = pipeline side, slave = register file.
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic                     init_busy;
    logic                     we0;
    logic [ADDR_W-1:0]        waddr0;
    logic [DATA_W-1:0]        wdata0;
    logic                     we1;
    logic [ADDR_W-1:0]        waddr1;
    logic [DATA_W-1:0]        wdata1;
    logic [NUM_RD-1:0]        re;
    logic [NUM_RD*ADDR_W-1:0] raddr;
    logic [NUM_RD*DATA_W-1:0] rdata;
    logic                     sb_set;
    logic [ADDR_W-1:0]        sb_addr;
    logic [NUM_RD-1:0]        sb_busy;

    modport master (
        input  init_busy, rdata, sb_busy,
        output we0, waddr0, wdata0, we1, waddr1, wdata1, re, raddr, sb_set, sb_addr
    );

    modport slave (
        output init_busy, rdata, sb_busy,
        input  we0, waddr0, wdata0, we1, waddr1, wdata1, re, raddr, sb_set, sb_addr
    );
endinterface

// File: rtl/regfile_rd_port.sv
// One read port: write-to-read bypass mux plus its RAW stall term.
//   en       : port enabled and register file in RUN
//   raddr    : this port's address
//   w1_ok/w0_ok, waddrN, wdataN : qualified commits this cycle
//   rf_word  : array contents at raddr
//   pend     : pending bit at raddr
//   rdata    : read result (combinational)
//   sb_busy  : stall, pending and not satisfied by a same-cycle commit
module regfile_rd_port
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              en,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              w1_ok,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              w0_ok,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] rf_word,
    input  logic              pend,
    output logic [DATA_W-1:0] rdata,
    output logic              sb_busy
);
    logic hit1, hit0, is_zero;

    assign hit1    = w1_ok && (waddr1 == raddr);
    assign hit0    = w0_ok && (waddr0 == raddr);
    assign is_zero = (ZERO_REG != 0) && (raddr == '0);

    always_comb begin
        rdata = ZERO_WORD[DATA_W-1:0];
        if (!en || is_zero) rdata = ZERO_WORD[DATA_W-1:0];
        else if (hit1)      rdata = wdata1;
        else if (hit0)      rdata = wdata0;
        else                rdata = rf_word;
    end

    // A committing write this cycle feeds the read via bypass, so no stall.
    assign sb_busy = en && pend && !(hit1 || hit0);
endmodule

// File: rtl/regfile_mp.sv
// Multi-port GPR file: two write-back ports, NUM_RD bypassed read ports,
// per-register pending-write scoreboard, and a post-reset clear sequencer.
//   clk, rst : clock, synchronous active-high reset
//   bus      : regfile_mp_if slave (write, read, scoreboard, init_busy)
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    state_t             state;
    logic [ADDR_W-1:0]  cnt;
    logic [DATA_W-1:0]  regs [DEPTH];
    logic [DEPTH-1:0]   pending, pend_nxt;
    logic               run, w0_ok, w1_ok, sb_ok;

    // rst overrides the state so outputs are quiet even if rst arrives during RUN.
    assign run           = (state == ST_RUN) && !rst;
    assign bus.init_busy = !run;

    assign w0_ok = run && (bus.we0 == EN_ON) && !((ZERO_REG != 0) && (bus.waddr0 == '0));
    assign w1_ok = run && (bus.we1 == EN_ON) && !((ZERO_REG != 0) && (bus.waddr1 == '0));
    assign sb_ok = run && (bus.sb_set == EN_ON) && !((ZERO_REG != 0) && (bus.sb_addr == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else if (state == ST_INIT) begin
            cnt <= cnt + 1'b1;
            if (cnt == ADDR_W'(DEPTH - 1)) state <= ST_RUN;
        end
    end

    // Array has no reset; the sequencer zeroes one entry per INIT cycle.
    // Port 1 is written last so it wins an address collision.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            regs[cnt] <= ZERO_WORD[DATA_W-1:0];
        end else begin
            if (w0_ok) regs[bus.waddr0] <= bus.wdata0;
            if (w1_ok) regs[bus.waddr1] <= bus.wdata1;
        end
    end

    // Set applied after clears: the newly issued instruction owns the register.
    always_comb begin
        pend_nxt = pending;
        if (w0_ok) pend_nxt[bus.waddr0] = 1'b0;
        if (w1_ok) pend_nxt[bus.waddr1] = 1'b0;
        if (sb_ok) pend_nxt[bus.sb_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) pending <= '0;
        else     pending <= pend_nxt;
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;
        logic              busy;

        assign ra = bus.raddr[i*ADDR_W +: ADDR_W];

        regfile_rd_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_rd (
            .en      (run && (bus.re[i] == EN_ON)),
            .raddr   (ra),
            .w1_ok   (w1_ok),
            .waddr1  (bus.waddr1),
            .wdata1  (bus.wdata1),
            .w0_ok   (w0_ok),
            .waddr0  (bus.waddr0),
            .wdata0  (bus.wdata0),
            .rf_word (regs[ra]),
            .pend    (pending[ra]),
            .rdata   (rd),
            .sb_busy (busy)
        );

        assign bus.rdata[i*DATA_W +: DATA_W] = rd;
        assign bus.sb_busy[i]                = busy;
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (DATA_W=32, ADDR_W=5, NUM_RD=2, ZERO_REG=1).
module tb_regfile_mp;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   n;

    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.we0 = 0; bus.waddr0 = '0; bus.wdata0 = '0;
        bus.we1 = 0; bus.waddr1 = '0; bus.wdata1 = '0;
        bus.sb_set = 0; bus.sb_addr = '0;
    endtask

    task automatic rd(input logic [1:0] en, input logic [4:0] a1, input logic [4:0] a0);
        bus.re    = en;
        bus.raddr = {a1, a0};
    endtask

    task automatic count_init();
        n = 0;
        while (bus.init_busy && n < 100) begin
            tick();
            n++;
        end
    endtask

    initial begin
        idle();
        rd(2'b11, 5'd5, 5'd5);

        // Reset held for two cycles.
        tick(); tick();
        #1;
        chk("rst_init_busy", 64'(bus.init_busy), 64'd1);
        chk("rst_rdata",     64'(bus.rdata),     64'd0);
        chk("rst_sb_busy",   64'(bus.sb_busy),   64'd0);
        rst = 1'b0;
        #1;
        chk("init_busy_after_rst", 64'(bus.init_busy), 64'd1);
        count_init();
        chk("init_len", 64'(n), 64'd32);
        #1;
        chk("r5_after_init", 64'(bus.rdata[31:0]), 64'd0);

        // Write r5, check bypass then array.
        bus.we0 = 1; bus.waddr0 = 5'd5; bus.wdata0 = 32'h1234;
        #1;
        chk("r5_bypass", 64'(bus.rdata), {32'h1234, 32'h1234});
        tick();
        idle();
        #1;
        chk("r5_array", 64'(bus.rdata[31:0]), 64'h1234);
        bus.re = 2'b00;
        #1;
        chk("re_off", 64'(bus.rdata), 64'd0);
        bus.re = 2'b11;

        // Reset, then re-pulse reset 10 cycles into INIT.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (10) tick();
        chk("mid_init_busy",  64'(bus.init_busy), 64'd1);
        chk("mid_init_rdata", 64'(bus.rdata),     64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        count_init();
        chk("init_len_restart", 64'(n), 64'd32);
        #1;
        chk("r5_cleared", 64'(bus.rdata[31:0]), 64'd0);

        // Dual write collision on r7.
        rd(2'b11, 5'd5, 5'd7);
        bus.we0 = 1; bus.waddr0 = 5'd7; bus.wdata0 = 32'h1111;
        bus.we1 = 1; bus.waddr1 = 5'd7; bus.wdata1 = 32'h2222;
        #1;
        chk("collide_bypass", 64'(bus.rdata[31:0]), 64'h2222);
        tick();
        idle();
        #1;
        chk("collide_array", 64'(bus.rdata[31:0]), 64'h2222);

        // Zero register: writes and claims are dropped.
        rd(2'b11, 5'd0, 5'd0);
        bus.we0 = 1; bus.waddr0 = 5'd0; bus.wdata0 = 32'hDEAD;
        #1;
        chk("r0_same_cycle", 64'(bus.rdata), 64'd0);
        tick();
        idle();
        bus.sb_set = 1; bus.sb_addr = 5'd0;
        #1;
        chk("r0_after_write", 64'(bus.rdata), 64'd0);
        tick();
        idle();
        #1;
        chk("r0_sb_busy", 64'(bus.sb_busy), 64'd0);

        // Per-port bypass: r3 holds 5, port1 sees we0 to r9.
        bus.we0 = 1; bus.waddr0 = 5'd3; bus.wdata0 = 32'h5;
        tick();
        idle();
        rd(2'b11, 5'd9, 5'd3);
        bus.we0 = 1; bus.waddr0 = 5'd9; bus.wdata0 = 32'hABCD;
        #1;
        chk("bypass_ports", 64'(bus.rdata), {32'hABCD, 32'h5});
        tick();
        idle();

        // Scoreboard on r4.
        bus.sb_set = 1; bus.sb_addr = 5'd4;
        tick();
        idle();
        rd(2'b01, 5'd4, 5'd4);
        #1;
        chk("sb_pending", 64'(bus.sb_busy), 64'b01);
        bus.we0 = 1; bus.waddr0 = 5'd4; bus.wdata0 = 32'h44;
        #1;
        chk("sb_commit_busy",  64'(bus.sb_busy),       64'd0);
        chk("sb_commit_data",  64'(bus.rdata[31:0]),   64'h44);
        tick();
        idle();
        rd(2'b11, 5'd4, 5'd4);
        #1;
        chk("sb_cleared", 64'(bus.sb_busy), 64'd0);
        bus.sb_set = 1; bus.sb_addr = 5'd4;
        bus.we1 = 1; bus.waddr1 = 5'd4; bus.wdata1 = 32'h99;
        #1;
        chk("sb_set_clr_same", 64'(bus.sb_busy), 64'd0);
        tick();
        idle();
        #1;
        chk("sb_set_wins",  64'(bus.sb_busy), 64'b11);
        chk("sb_set_data",  64'(bus.rdata),   {32'h99, 32'h99});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
